// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
// The line is double-flopped, a start bit is confirmed half a bit after
// the falling edge, then each data bit and the stop bit are sampled one
// full bit period apart (mid-bit). Good bytes go to a valid/ack holding
// register; bad stop bits and full-register drops produce 1-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 2605
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    // Counter terminal values: start re-check and full-bit sample points.
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic [1:0]    sync_q;
    logic          rxs;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;

    logic          half_hit;
    logic          bit_hit;
    logic          load_ok;
    logic [CW-1:0] cnt_d;
    logic [2:0]    idx_d;
    logic [7:0]    sh_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxs = sync_q[1];

    // Sample-point decode and next values for counter, index and shifter.
    always_comb begin
        half_hit = (cnt_q == HALF_END);
        bit_hit  = (cnt_q == BIT_END);
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q + 3'd1;
        sh_d     = {rxs, sh_q[7:1]};
        // A full register can still take a byte if it is being acked now.
        load_ok  = !valid_q || rx_ack;
    end

    // Receive FSM plus holding register and error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // Plain ack; a good frame completing this cycle overrides it.
            if (valid_q && rx_ack) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (half_hit) begin
                        cnt_q <= '0;
                        if (!rxs) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            // Line went back high: treat as a glitch.
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                DATA: begin
                    if (bit_hit) begin
                        cnt_q <= '0;
                        sh_q  <= sh_d;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                STOP: begin
                    if (bit_hit) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            // Back to IDLE mid stop bit so a fast sender's
                            // next start edge is not missed.
                            state_q <= IDLE;
                            if (load_ok) begin
                                data_q  <= sh_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line or break must not spawn new frames.
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a byte-level model
// of the receiver's holding register and error pulses.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int CPB2 = 2605;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] data_out;
    logic       rx_valid, frame_err, overrun;

    logic       rxd2 = 1'b1;
    logic       rx_ack2 = 1'b0;
    logic [7:0] data_out2;
    logic       rx_valid2, frame_err2, overrun2;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rx_ack(rx_ack),
        .data_out(data_out), .rx_valid(rx_valid),
        .frame_err(frame_err), .overrun(overrun)
    );

    uart_rx dut_dflt (
        .clk(clk), .reset(reset), .rxd(rxd2), .rx_ack(rx_ack2),
        .data_out(data_out2), .rx_valid(rx_valid2),
        .frame_err(frame_err2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and edge bookkeeping, sampled away from the active edge.
    int fe_hi = 0, fe_rise = 0, ov_hi = 0, ov_rise = 0, both = 0;
    int v_rise = 0, rise_cyc = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0, v_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_err) fe_hi <= fe_hi + 1;
        if (frame_err && !fe_prev) fe_rise <= fe_rise + 1;
        if (overrun) ov_hi <= ov_hi + 1;
        if (overrun && !ov_prev) ov_rise <= ov_rise + 1;
        if (frame_err && overrun) both <= both + 1;
        if (rx_valid && !v_prev) begin
            v_rise   <= v_rise + 1;
            rise_cyc <= cyc;
        end
        fe_prev <= frame_err;
        ov_prev <= overrun;
        v_prev  <= rx_valid;
    end

    // Stimulus state
    int         kc = 0;
    int         ack_at = -1;
    bit         auto_ack = 1'b0;
    int         fall_cyc = 0;
    logic [7:0] got[$];

    // One clock of line level; optional auto-ack or ack at a frame offset.
    task automatic tick(input logic b);
        rxd    = b;
        rx_ack = 1'b0;
        if (auto_ack && rx_valid) begin
            got.push_back(data_out);
            rx_ack = 1'b1;
        end
        if (kc == ack_at) rx_ack = 1'b1;
        kc++;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb, input int ack_k);
        kc       = 0;
        ack_at   = ack_k;
        fall_cyc = cyc;
        for (int i = 0; i < CPB; i++) tick(1'b0);
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < CPB; i++) tick(b[j]);
        for (int i = 0; i < CPB; i++) tick(stopb);
        ack_at = -1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(4);
        checks++;
        if (rx_valid !== 1'b0 || data_out !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h fe=%b ov=%b want 0 00 0 0",
                     rx_valid, data_out, frame_err, overrun);
        end
        checks++;
        if (rx_valid2 !== 1'b0 || data_out2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_state_dflt: got v=%b d=%h want 0 00", rx_valid2, data_out2);
        end
        reset = 1'b1;
        idle(4);
        checks++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL after_release: got v=%b fe=%b ov=%b want 0 0 0", rx_valid, frame_err, overrun);
        end
    endtask

    task automatic test_single();
        int r0, exp_rise, diff;
        r0 = v_rise;
        send_frame(8'hA5, 1'b1, -1);
        idle(4);
        exp_rise = fall_cyc + 3 + HALF + 9 * CPB + 1;
        diff = rise_cyc - exp_rise;
        checks++;
        if (v_rise - r0 != 1 || diff > 2 || diff < -2) begin
            failures++;
            $display("FAIL single_latency: rises=%0d rise_cyc=%0d want 1 rise near %0d",
                     v_rise - r0, rise_cyc, exp_rise);
        end
        checks++;
        if (rx_valid !== 1'b1 || data_out !== 8'hA5) begin
            failures++;
            $display("FAIL single_data: got v=%b d=%h want 1 a5", rx_valid, data_out);
        end
        ack_pulse();
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: got v=%b want 0", rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ov_rise;
        got.delete();
        auto_ack = 1'b1;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(6);
        auto_ack = 1'b0;
        checks++;
        if (got.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d bytes want 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 8'h00 || got[1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_order: got %h %h want 00 ff", got[0], got[1]);
            end
        end
        checks++;
        if (ov_rise != o0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overrun: overruns=%0d v=%b want 0 0", ov_rise - o0, rx_valid);
        end
        // Ack lands on the second frame's stop-sample cycle.
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 2 + HALF + 9 * CPB);
        idle(4);
        checks++;
        if (rx_valid !== 1'b1 || data_out !== 8'hFF || ov_rise != o0) begin
            failures++;
            $display("FAIL ack_on_stop: got v=%b d=%h ov=%0d want 1 ff 0",
                     rx_valid, data_out, ov_rise - o0);
        end
        ack_pulse();
        idle(2);
    endtask

    task automatic test_glitch();
        int r0;
        r0 = v_rise;
        for (int i = 0; i < 4; i++) tick(1'b0);
        idle(3 * CPB);
        checks++;
        if (rx_valid !== 1'b0 || v_rise != r0) begin
            failures++;
            $display("FAIL glitch_ignored: got v=%b rises=%0d want 0 0", rx_valid, v_rise - r0);
        end
        send_frame(8'h3C, 1'b1, -1);
        idle(4);
        checks++;
        if (rx_valid !== 1'b1 || data_out !== 8'h3C) begin
            failures++;
            $display("FAIL glitch_next: got v=%b d=%h want 1 3c", rx_valid, data_out);
        end
        ack_pulse();
        idle(2);
    endtask

    task automatic test_frame_err();
        int f0, h0, r0;
        f0 = fe_rise; h0 = fe_hi; r0 = v_rise;
        send_frame(8'h81, 1'b0, -1);
        for (int i = 0; i < 40; i++) tick(1'b0);
        checks++;
        if (fe_rise - f0 != 1 || fe_hi - h0 != 1) begin
            failures++;
            $display("FAIL frame_err_pulse: pulses=%0d hi_cycles=%0d want 1 1", fe_rise - f0, fe_hi - h0);
        end
        checks++;
        if (rx_valid !== 1'b0 || v_rise != r0) begin
            failures++;
            $display("FAIL frame_err_novalid: got v=%b want 0", rx_valid);
        end
        idle(2 * CPB);
        send_frame(8'h5A, 1'b1, -1);
        idle(4);
        checks++;
        if (rx_valid !== 1'b1 || data_out !== 8'h5A || fe_rise - f0 != 1) begin
            failures++;
            $display("FAIL frame_err_recover: got v=%b d=%h fe=%0d want 1 5a 1",
                     rx_valid, data_out, fe_rise - f0);
        end
        ack_pulse();
        idle(2);
    endtask

    task automatic test_overrun_reset();
        int o0, f0, r0;
        o0 = ov_rise;
        send_frame(8'h11, 1'b1, -1);
        idle(3);
        send_frame(8'h22, 1'b1, -1);
        idle(4);
        checks++;
        if (ov_rise - o0 != 1 || ov_hi - o0 < 0) begin
            failures++;
            $display("FAIL overrun_pulse: got %0d pulses want 1", ov_rise - o0);
        end
        checks++;
        if (rx_valid !== 1'b1 || data_out !== 8'h11) begin
            failures++;
            $display("FAIL overrun_keep: got v=%b d=%h want 1 11", rx_valid, data_out);
        end
        // Third frame (0xFF) reset during its data bits while the line is high.
        for (int i = 0; i < CPB; i++) tick(1'b0);
        for (int i = 0; i < 3 * CPB; i++) tick(1'b1);
        reset = 1'b0;
        idle(3);
        checks++;
        if (rx_valid !== 1'b0 || data_out !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: got v=%b d=%h fe=%b ov=%b want 0 00 0 0",
                     rx_valid, data_out, frame_err, overrun);
        end
        reset = 1'b1;
        o0 = ov_rise; f0 = fe_rise; r0 = v_rise;
        idle(8 * CPB);
        checks++;
        if (ov_rise != o0 || fe_rise != f0 || v_rise != r0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_pulses: ov=%0d fe=%0d rises=%0d v=%b want 0 0 0 0",
                     ov_rise - o0, fe_rise - f0, v_rise - r0, rx_valid);
        end
    endtask

    // Byte-level model: holding register plus counts of each error kind.
    task automatic test_random();
        bit         m_valid;
        logic [7:0] m_data;
        int         m_fe, m_ov, f0, o0;
        logic [7:0] b;
        bit         bad;
        m_valid = 1'b0; m_data = 8'h00; m_fe = 0; m_ov = 0;
        f0 = fe_rise; o0 = ov_rise;
        for (int n = 0; n < 14; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(b, !bad, -1);
            if (bad) begin
                m_fe++;
                idle(2 * CPB);
            end else begin
                if (m_valid) m_ov++;
                else begin
                    m_data  = b;
                    m_valid = 1'b1;
                end
                idle($urandom_range(0, 3));
            end
            checks++;
            if (rx_valid !== m_valid || (m_valid && data_out !== m_data)) begin
                failures++;
                $display("FAIL rand_hold[%0d]: got v=%b d=%h want v=%b d=%h",
                         n, rx_valid, data_out, m_valid, m_data);
            end
            checks++;
            if (fe_rise - f0 != m_fe || ov_rise - o0 != m_ov) begin
                failures++;
                $display("FAIL rand_errs[%0d]: got fe=%0d ov=%0d want fe=%0d ov=%0d",
                         n, fe_rise - f0, ov_rise - o0, m_fe, m_ov);
            end
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                m_valid = 1'b0;
            end
        end
        if (m_valid) ack_pulse();
        idle(2);
    endtask

    task automatic test_pulses();
        checks++;
        if (fe_hi != fe_rise || ov_hi != ov_rise || both != 0) begin
            failures++;
            $display("FAIL pulse_shape: fe_hi=%0d fe_rise=%0d ov_hi=%0d ov_rise=%0d both=%0d want hi==rise both=0",
                     fe_hi, fe_rise, ov_hi, ov_rise, both);
        end
    endtask

    task automatic test_loopback();
        logic [9:0] fr;
        bit         seen;
        fr   = {1'b1, 8'hC3, 1'b0};
        seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
            rxd2 = fr[j];
            for (int i = 0; i < CPB2; i++) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rx_valid2) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen || data_out2 !== 8'hC3 || frame_err2 !== 1'b0 || overrun2 !== 1'b0) begin
            failures++;
            $display("FAIL loopback_default: got v=%b d=%h want 1 c3", rx_valid2, data_out2);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun_reset();
        test_random();
        test_pulses();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with `uart_tx`: samples an asynchronous 8N1 line (`rxd`) and delivers each received byte through a one-entry holding register with a valid/ack handshake. Sits downstream of `uart_tx` in loopback and on the external RX pin. It uses the same baud convention as `uart_tx`: one bit period is `CLKS_PER_BIT` clocks, which is 2605 at the default setting. Idle line is high, and frames are LSB first.

## Interface
- `CLKS_PER_BIT`, default 2605: clocks per bit period. Legal values are ≥ 4. `HALF` = floor(`CLKS_PER_BIT`/2).
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low reset. The block is in reset while `reset` = 0.
- `rxd`, input, 1: asynchronous serial input. Idle high.
- `rx_ack`, input, 1: consumer acknowledges `data_out`. Sampled only while `rx_valid` = 1.
- `data_out`, output, 8: last accepted byte. Stable while `rx_valid` = 1.
- `rx_valid`, output, 1: a byte is held. Level signal, cleared by `rx_ack`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled 0.
- `overrun`, output, 1: one-cycle pulse when a good frame completes while the holding register is full.

## Operation
- Synchronizer:
  - `rxd` passes through 2 flops. Both reset to 1.
  - All FSM decisions use the synchronized value `rxs`.
- Bit counter:
  - `cnt` is $clog2(`CLKS_PER_BIT`) bits wide.
  - It is cleared on every state change and on every bit sample. Otherwise it increments.
- Bit index: `idx` is 3 bits and counts data bits 0..7.
- Shift register `sh` (8 bits): each data sample shifts right and inserts `rxs` at bit 7. After 8 samples, `sh[0]` holds the first bit received.
- States:
  - IDLE: if `rxs` = 0, go to START with `cnt` = 0.
  - START: when `cnt` = `HALF`-1, re-check `rxs`.
    - `rxs` = 0: go to DATA with `cnt` = 0 and `idx` = 0.
    - `rxs` = 1: glitch. Return to IDLE silently; no output changes.
  - DATA: when `cnt` = `CLKS_PER_BIT`-1, sample `rxs` into `sh`.
    - If `idx` = 7, go to STOP.
    - Otherwise increment `idx`.
  - STOP: when `cnt` = `CLKS_PER_BIT`-1, sample `rxs`.
    - `rxs` = 1: good frame. Deliver per the holding rules below, then go to IDLE.
    - `rxs` = 0: pulse `frame_err`, discard `sh`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then go to IDLE. This prevents a held-low line or break from being parsed as new frames.
  - Any undefined encoding goes to IDLE.
- Holding register on a good frame:
  - `rx_valid` = 0: load `data_out` ← `sh`, set `rx_valid`.
  - `rx_valid` = 1 and `rx_ack` = 1 in the same cycle: load the new byte and keep `rx_valid` = 1. No overrun.
  - `rx_valid` = 1 and `rx_ack` = 0: pulse `overrun`. Keep the old `data_out`. The new byte is dropped.
- `rx_ack` with `rx_valid` = 1 and no concurrent good frame: clear `rx_valid` next cycle.
- `rx_ack` while `rx_valid` = 0: ignored.
- Reset values:
  - State IDLE; `cnt`, `idx`, `sh` = 0.
  - Synchronizer flops = 1.
  - `data_out` = 0x00; `rx_valid`, `frame_err`, `overrun` = 0.
- Reset mid-frame aborts the frame: no `rx_valid`, `frame_err` or `overrun`. After release, the block waits for the next falling edge of `rxs`.

## Timing
- Synchronizer latency: a change on `rxd` is visible to the FSM 2 clocks later.
- Start-bit check: `HALF` clocks after entering START.
- Data bit k is sampled (k+1)·`CLKS_PER_BIT` clocks after the start check, i.e. mid-bit. The stop bit is sampled 9·`CLKS_PER_BIT` clocks after the start check.
- Frame latency: `rx_valid`, `frame_err` and `overrun` are registered. They assert the cycle after the stop-sample cycle.
- Total latency from the `rxd` falling edge to `rx_valid` high is 3 + `HALF` + 9·`CLKS_PER_BIT` + 1 clocks (±1 for edge phase). Bench checks allow ±2 clocks.
- The block is back in IDLE the cycle after a good stop sample. This accepts a new start bit half a bit before the nominal stop end, which tolerates transmitter clocks up to ~4% fast.
- `frame_err` and `overrun` are exactly 1 cycle wide and never asserted together.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 unless stated.
- Single byte: drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → `rx_valid` rises within the latency window, `data_out` = 0xA5. Pulse `rx_ack` → `rx_valid` = 0 the next cycle.
- Back-to-back with ack: send 0x00 then 0xFF with no idle gap, acking each byte on the cycle `rx_valid` rises → both bytes delivered in order, no `overrun`. Repeat with the ack coincident with the second stop sample → `data_out` = 0xFF, `rx_valid` stays 1.
- Start glitch: hold `rxd` low for 4 clocks, then high → no `rx_valid`, FSM returns to IDLE. A following 0x3C frame is received correctly.
- Framing error: send 0x81 with stop = 0, then hold the line low for 40 clocks → one `frame_err` pulse, `rx_valid` stays 0, FSM stays in WAIT_HIGH. After `rxd` returns high, a 0x5A frame is received correctly.
- Overrun and reset: receive 0x11 without ack, then receive 0x22 → one `overrun` pulse, `data_out` stays 0x11. Assert `reset` = 0 in the middle of a third frame → all outputs return to reset values and no pulses follow.
- Loopback at default `CLKS_PER_BIT` = 2605: connect `uart_tx.txd` to `rxd` and send 0xC3 → `data_out` = 0xC3.
